pipeline_wb_stage_param: RTL and testbench
==========================================

Name: pipeline_wb_stage_param

Overview:
- Parametrised write-back stage for the RV pipeline, successor to the fixed 64-bit write-back stage.
- Adds XLEN/PC width parameters, load-data alignment and sign/zero extension, a valid bit with flush, x0 write suppression, and a retired-instruction counter.
- Sits between the MEM stage and the register file. Its registered outputs drive the regfile write port and the forwarding unit.

Parameters:
- XLEN, 64, datapath width; legal values are 32 or 64.
- PC_W, 64, PC width.
- CNT_W, 64, width of the retired-instruction counter.
- OFF_W (localparam), $clog2(XLEN/8), width of the byte-offset field.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold the WB register.
- flush  in  1  load a bubble into the WB register.
- valid_MEM  in  1  MEM-stage instruction valid.
- rf_wr_sel  in  2  writeback source select: 00 zero, 01 pc+4, 10 ALU result, 11 load data.
- alu_result_MEM  in  XLEN  ALU result.
- mem_data_MEM  in  XLEN  raw aligned memory word.
- mem_size_MEM  in  2  load size: 00 byte, 01 half, 10 word, 11 double.
- mem_unsigned_MEM  in  1  1 = zero-extend the load, 0 = sign-extend.
- mem_off_MEM  in  OFF_W  byte offset of the load address within the word.
- rd_MEM  in  5  destination register.
- reg_write_MEM  in  1  register write enable.
- pc_MEM  in  PC_W  instruction PC.
- write_data_WB  out  XLEN  regfile write data.
- rd_WB  out  5  regfile write address.
- reg_write_WB  out  1  regfile write enable.
- valid_WB  out  1  WB register holds a real instruction.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- All state updates on posedge clk. Priority: reset > flush > stall > load.
- Reset: write_data_WB=0, rd_WB=0, reg_write_WB=0, valid_WB=0, instret=0. Reset asserted mid-operation discards the held instruction.
- Load-data formatting (combinational):
  - Shift: shifted = mem_data_MEM >> (8*mem_off_MEM).
  - Field: take the low 8, 16, 32 or XLEN bits of shifted according to mem_size_MEM.
  - Extension: zero-extend if mem_unsigned_MEM=1, else sign-extend from the field MSB.
  - XLEN=32: size 11 is treated as size 10.
  - Misaligned offsets are not checked; the shifted bits are used as-is.
- Source select (combinational), result is next_data:
  - 00 -> 0.
  - 01 -> pc_MEM+4, truncated to PC_W (wraps), then zero-extended or truncated to XLEN.
  - 10 -> alu_result_MEM.
  - 11 -> formatted load data.
- Load (stall=0, flush=0):
  - valid_WB <= valid_MEM.
  - rd_WB <= rd_MEM.
  - write_data_WB <= next_data.
  - reg_write_WB <= valid_MEM & reg_write_MEM & (rd_MEM != 0).
- Stall (flush=0): all WB registers hold. reg_write_WB stays asserted if already set; the regfile rewriting the same value is harmless.
- Flush: valid_WB=0, reg_write_WB=0, rd_WB=0, write_data_WB=0, regardless of stall. Flush takes effect in the same edge.
- instret increments by 1, wrapping modulo 2^CNT_W, on any edge where reset=0, flush=0, stall=0 and valid_MEM=1.
  - instret counts instructions entering WB, including those with rd=0 or no register write.
  - It does not change on stall, flush, or bubbles.
- Latency: exactly 1 cycle from MEM inputs to WB outputs; no combinational path from inputs to outputs.

Test Plan:
- Reset: hold reset for 2 cycles with valid_MEM=1 on the inputs -> all outputs 0; instret=0 on the first edge after release with no valid input.
- Load sign/zero (XLEN=64): mem_data=0x0000_0000_8000_F080, sel=11, size=00, off=0.
  - signed -> 0xFFFF_FFFF_FFFF_FF80.
  - off=1, unsigned -> 0xF0.
  - size=01, off=2, signed -> 0xFFFF_FFFF_FFFF_8000.
- pc+4 and x0:
  - sel=01, pc=0x1000, rd=5, reg_write=1 -> write_data_WB=0x1004, reg_write_WB=1 one cycle later.
  - Same input with rd=0 -> reg_write_WB=0, instret still +1.
- Stall/flush priority:
  - Load ALU result 0x55 into rd=3, then stall=1 for 3 cycles with new inputs -> outputs hold 0x55/3 and instret is unchanged.
  - stall=1 and flush=1 together -> bubble loaded, valid_WB=0.
- Counter wrap: CNT_W=4, 17 consecutive valid instructions with no stall -> instret=1.
- XLEN=32 build: size=11 with mem_data=0x8000_0000, signed -> 0x8000_0000; pc=0xFFFF_FFFC with PC_W=32, sel=01 -> 0x0000_0000.

Source files
------------

// File: rtl/pipeline_wb_stage_param.sv
// Write-back stage register for the RV pipeline.
// Formats load data (shift, field select, sign/zero extend), selects the
// write-back source and registers the result for the regfile write port
// and forwarding unit. Also counts instructions entering WB.
module pipeline_wb_stage_param #(
  parameter int XLEN  = 64,
  parameter int PC_W  = 64,
  parameter int CNT_W = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       valid_MEM,
  input  logic [1:0]                 rf_wr_sel,
  input  logic [XLEN-1:0]            alu_result_MEM,
  input  logic [XLEN-1:0]            mem_data_MEM,
  input  logic [1:0]                 mem_size_MEM,
  input  logic                       mem_unsigned_MEM,
  input  logic [$clog2(XLEN/8)-1:0]  mem_off_MEM,
  input  logic [4:0]                 rd_MEM,
  input  logic                       reg_write_MEM,
  input  logic [PC_W-1:0]            pc_MEM,
  output logic [XLEN-1:0]            write_data_WB,
  output logic [4:0]                 rd_WB,
  output logic                       reg_write_WB,
  output logic                       valid_WB,
  output logic [CNT_W-1:0]           instret
);

  localparam int OFF_W = $clog2(XLEN/8);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] field_mask;
  logic            field_msb;
  logic [XLEN-1:0] load_data;
  logic [PC_W-1:0] pc_plus4;
  logic [XLEN-1:0] next_data;
  logic            retire;

  // Load alignment: shift the addressed byte down, keep the field, extend.
  // The field is isolated with a mask rather than slices so that one body
  // serves both XLEN=32 and XLEN=64; with XLEN=32 a double-size load
  // collapses onto the full-word mask and bit 31, i.e. behaves as a word.
  always_comb begin
    shifted = mem_data_MEM >> {mem_off_MEM, 3'b000};
    case (mem_size_MEM)
      2'b00: begin
        field_mask = XLEN'(8'hFF);
        field_msb  = shifted[7];
      end
      2'b01: begin
        field_mask = XLEN'(16'hFFFF);
        field_msb  = shifted[15];
      end
      2'b10: begin
        field_mask = XLEN'(32'hFFFF_FFFF);
        field_msb  = shifted[31];
      end
      default: begin
        field_mask = '1;
        field_msb  = shifted[XLEN-1];
      end
    endcase
    load_data = shifted & field_mask;
    if (!mem_unsigned_MEM && field_msb) begin
      load_data = load_data | ~field_mask;
    end
  end

  // Write-back source select; pc+4 wraps at PC_W before resizing to XLEN.
  always_comb begin
    pc_plus4 = pc_MEM + PC_W'(4);
    case (rf_wr_sel)
      2'b00:   next_data = '0;
      2'b01:   next_data = XLEN'(pc_plus4);
      2'b10:   next_data = alu_result_MEM;
      default: next_data = load_data;
    endcase
  end

  assign retire = !flush && !stall && valid_MEM;

  // WB pipeline register: reset > flush > stall (hold) > load.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      write_data_WB <= '0;
      rd_WB         <= '0;
      reg_write_WB  <= 1'b0;
      valid_WB      <= 1'b0;
    end else if (!stall) begin
      write_data_WB <= next_data;
      rd_WB         <= rd_MEM;
      reg_write_WB  <= valid_MEM && reg_write_MEM && (rd_MEM != 5'd0);
      valid_WB      <= valid_MEM;
    end
  end

  // Retired-instruction counter, wraps modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + CNT_W'(1);
    end
  end

  logic unused_off_w;
  assign unused_off_w = (OFF_W == 0);

endmodule

// File: tb/tb_pipeline_wb_stage_param.sv
// Bench for pipeline_wb_stage_param: three builds run in lockstep
// (64-bit, 64-bit with 4-bit counter, 32-bit) against an arithmetic model.
module tb_pipeline_wb_stage_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, flush, valid, uns, rw;
  logic [1:0]  sel, size;
  logic [63:0] alu, data, pc;
  logic [2:0]  off;
  logic [4:0]  rd;

  logic [63:0] wd0, wd1, cnt0;
  logic [31:0] wd2, cnt2;
  logic [3:0]  cnt1;
  logic [4:0]  rd0, rd1, rd2;
  logic        rw0, rw1, rw2, v0, v1, v2;

  pipeline_wb_stage_param #(.XLEN(64), .PC_W(64), .CNT_W(64)) dut64 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_MEM(valid),
    .rf_wr_sel(sel), .alu_result_MEM(alu), .mem_data_MEM(data),
    .mem_size_MEM(size), .mem_unsigned_MEM(uns), .mem_off_MEM(off),
    .rd_MEM(rd), .reg_write_MEM(rw), .pc_MEM(pc),
    .write_data_WB(wd0), .rd_WB(rd0), .reg_write_WB(rw0), .valid_WB(v0),
    .instret(cnt0));

  pipeline_wb_stage_param #(.XLEN(64), .PC_W(64), .CNT_W(4)) dut_c4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_MEM(valid),
    .rf_wr_sel(sel), .alu_result_MEM(alu), .mem_data_MEM(data),
    .mem_size_MEM(size), .mem_unsigned_MEM(uns), .mem_off_MEM(off),
    .rd_MEM(rd), .reg_write_MEM(rw), .pc_MEM(pc),
    .write_data_WB(wd1), .rd_WB(rd1), .reg_write_WB(rw1), .valid_WB(v1),
    .instret(cnt1));

  pipeline_wb_stage_param #(.XLEN(32), .PC_W(32), .CNT_W(32)) dut32 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_MEM(valid),
    .rf_wr_sel(sel), .alu_result_MEM(alu[31:0]), .mem_data_MEM(data[31:0]),
    .mem_size_MEM(size), .mem_unsigned_MEM(uns), .mem_off_MEM(off[1:0]),
    .rd_MEM(rd), .reg_write_MEM(rw), .pc_MEM(pc[31:0]),
    .write_data_WB(wd2), .rd_WB(rd2), .reg_write_WB(rw2), .valid_WB(v2),
    .instret(cnt2));

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mask(int w);
    return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic int xl_of(int i);
    return (i == 2) ? 32 : 64;
  endfunction

  function automatic int cw_of(int i);
    return (i == 0) ? 64 : ((i == 1) ? 4 : 32);
  endfunction

  // Value the regfile should receive, from the select/format rules.
  function automatic logic [63:0] model_next(int xl, int pw);
    logic [63:0] xm, v;
    int nbits, o;
    xm = mask(xl);
    case (sel)
      2'd0: return 64'd0;
      2'd1: return ((pc + 64'd4) & mask(pw)) & xm;
      2'd2: return alu & xm;
      default: begin
        o = int'(off) % (xl / 8);
        nbits = 8 << size;
        if (nbits > xl) nbits = xl;
        v = (data & xm) >> (8 * o);
        if (nbits < 64) begin
          v = v & mask(nbits);
          if (!uns && v >= (64'd1 << (nbits - 1))) v = v - (64'd1 << nbits);
        end
        return v & xm;
      end
    endcase
  endfunction

  logic [63:0] m_wd [3];
  logic [4:0]  m_rd [3];
  logic        m_rw [3];
  logic        m_v  [3];
  logic [63:0] m_cnt[3];

  task automatic check_dut(int i, logic [63:0] a_wd, logic [4:0] a_rd,
                           logic a_rw, logic a_v, logic [63:0] a_cnt);
    chk($sformatf("write_data[%0d]", i), a_wd, m_wd[i]);
    chk($sformatf("rd[%0d]", i), {59'd0, a_rd}, {59'd0, m_rd[i]});
    chk($sformatf("reg_write[%0d]", i), {63'd0, a_rw}, {63'd0, m_rw[i]});
    chk($sformatf("valid[%0d]", i), {63'd0, a_v}, {63'd0, m_v[i]});
    chk($sformatf("instret[%0d]", i), a_cnt, m_cnt[i]);
  endtask

  // Advance the model by one edge from current inputs, clock, compare.
  task automatic step();
    logic [63:0] nd;
    for (int i = 0; i < 3; i++) begin
      nd = model_next(xl_of(i), xl_of(i));
      if (reset) begin
        m_wd[i] = '0; m_rd[i] = '0; m_rw[i] = 1'b0; m_v[i] = 1'b0; m_cnt[i] = '0;
      end else if (flush) begin
        m_wd[i] = '0; m_rd[i] = '0; m_rw[i] = 1'b0; m_v[i] = 1'b0;
      end else if (!stall) begin
        m_wd[i] = nd;
        m_rd[i] = rd;
        m_rw[i] = valid && rw && (rd != 5'd0);
        m_v[i]  = valid;
        if (valid) m_cnt[i] = (m_cnt[i] + 64'd1) & mask(cw_of(i));
      end
    end
    @(posedge clk);
    #1;
    check_dut(0, wd0, rd0, rw0, v0, cnt0);
    check_dut(1, wd1, rd1, rw1, v1, {60'd0, cnt1});
    check_dut(2, {32'd0, wd2}, rd2, rw2, v2, {32'd0, cnt2});
  endtask

  task automatic randomize_inputs();
    valid = 1'($urandom);
    sel   = 2'($urandom);
    alu   = {$urandom, $urandom};
    data  = {$urandom, $urandom};
    size  = 2'($urandom);
    uns   = 1'($urandom);
    off   = 3'($urandom);
    rd    = 5'($urandom);
    rw    = 1'($urandom);
    pc    = {$urandom, $urandom};
  endtask

  typedef struct {
    logic        valid;
    logic [1:0]  sel;
    logic [63:0] alu;
    logic [63:0] data;
    logic [1:0]  size;
    logic        uns;
    logic [2:0]  off;
    logic [4:0]  rd;
    logic        rw;
    logic [63:0] pc;
    logic [63:0] exp_wd;
    logic        exp_rw;
  } vec_t;

  vec_t tbl[10];
  logic [63:0] saved_cnt;

  initial begin
    //        v  sel  alu       data                     sz  u  off rd  rw pc        exp_wd                   exp_rw
    tbl[0] = '{1, 2'd3, 64'h0,   64'h0000_0000_8000_F080, 2'd0, 0, 3'd0, 5'd1, 1, 64'h0,    64'hFFFF_FFFF_FFFF_FF80, 1};
    tbl[1] = '{1, 2'd3, 64'h0,   64'h0000_0000_8000_F080, 2'd0, 1, 3'd1, 5'd2, 1, 64'h0,    64'h0000_0000_0000_00F0, 1};
    tbl[2] = '{1, 2'd3, 64'h0,   64'h0000_0000_8000_F080, 2'd1, 0, 3'd2, 5'd2, 1, 64'h0,    64'hFFFF_FFFF_FFFF_8000, 1};
    tbl[3] = '{1, 2'd3, 64'h0,   64'h0000_0000_8000_F080, 2'd2, 0, 3'd0, 5'd4, 1, 64'h0,    64'hFFFF_FFFF_8000_F080, 1};
    tbl[4] = '{1, 2'd3, 64'h0,   64'h0000_0000_8000_F080, 2'd3, 0, 3'd0, 5'd4, 1, 64'h0,    64'h0000_0000_8000_F080, 1};
    tbl[5] = '{1, 2'd1, 64'h0,   64'h0,                   2'd0, 0, 3'd0, 5'd5, 1, 64'h1000, 64'h0000_0000_0000_1004, 1};
    tbl[6] = '{1, 2'd1, 64'h0,   64'h0,                   2'd0, 0, 3'd0, 5'd0, 1, 64'h1000, 64'h0000_0000_0000_1004, 0};
    tbl[7] = '{1, 2'd2, 64'h55,  64'h0,                   2'd0, 0, 3'd0, 5'd3, 1, 64'h0,    64'h0000_0000_0000_0055, 1};
    tbl[8] = '{1, 2'd0, 64'h77,  64'hFF,                  2'd0, 0, 3'd0, 5'd9, 1, 64'h40,   64'h0,                   1};
    tbl[9] = '{0, 2'd2, 64'h99,  64'h0,                   2'd0, 0, 3'd0, 5'd9, 1, 64'h0,    64'h0000_0000_0000_0099, 0};

    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    valid = 1'b1; sel = 2'd2; alu = 64'h1234; data = '0; size = '0; uns = 1'b0;
    off = '0; rd = 5'd7; rw = 1'b1; pc = '0;

    // Reset held two cycles with a valid instruction presented.
    step();
    step();
    chk("reset_valid", {63'd0, v0}, 64'd0);
    reset = 1'b0; valid = 1'b0;
    step();
    chk("instret_after_reset", cnt0, 64'd0);

    // Directed vectors.
    for (int k = 0; k < 10; k++) begin
      valid = tbl[k].valid; sel = tbl[k].sel; alu = tbl[k].alu; data = tbl[k].data;
      size = tbl[k].size; uns = tbl[k].uns; off = tbl[k].off; rd = tbl[k].rd;
      rw = tbl[k].rw; pc = tbl[k].pc;
      step();
      chk($sformatf("tbl%0d_wd", k), wd0, tbl[k].exp_wd);
      chk($sformatf("tbl%0d_rw", k), {63'd0, rw0}, {63'd0, tbl[k].exp_rw});
    end
    chk("tbl_instret", cnt0, 64'd9);

    // Stall holds the register and the counter.
    valid = 1'b1; sel = 2'd2; alu = 64'h55; rd = 5'd3; rw = 1'b1;
    step();
    saved_cnt = m_cnt[0];
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      randomize_inputs();
      valid = 1'b1;
      step();
      chk("stall_wd", wd0, 64'h55);
      chk("stall_rd", {59'd0, rd0}, 64'd3);
      chk("stall_cnt", cnt0, saved_cnt);
    end

    // Flush wins over stall.
    flush = 1'b1;
    step();
    chk("flush_valid", {63'd0, v0}, 64'd0);
    chk("flush_wd", wd0, 64'd0);
    flush = 1'b0; stall = 1'b0;

    // Reset mid-operation discards the held instruction.
    valid = 1'b1; sel = 2'd2; alu = 64'hABCD; rd = 5'd8; rw = 1'b1;
    step();
    reset = 1'b1;
    step();
    chk("midreset_rw", {63'd0, rw0}, 64'd0);
    reset = 1'b0;

    // Counter wrap: 17 retirements into a 4-bit counter.
    for (int k = 0; k < 17; k++) begin
      randomize_inputs();
      valid = 1'b1;
      step();
    end
    chk("wrap_c4", {60'd0, cnt1}, 64'd1);
    chk("wrap_c64", cnt0, 64'd17);

    // 32-bit build corners.
    valid = 1'b1; sel = 2'd3; size = 2'd3; uns = 1'b0; off = '0;
    data = 64'h0000_0000_8000_0000; rd = 5'd6; rw = 1'b1;
    step();
    chk("x32_double", {32'd0, wd2}, 64'h0000_0000_8000_0000);
    sel = 2'd1; pc = 64'h0000_0000_FFFF_FFFC;
    step();
    chk("x32_pc_wrap", {32'd0, wd2}, 64'd0);
    chk("x64_pc_nowrap", wd0, 64'h0000_0001_0000_0000);

    // Random traffic with occasional stall, flush and reset.
    for (int k = 0; k < 400; k++) begin
      randomize_inputs();
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 96) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
